// File: rtl/opcode_sequencer.sv
// -----------------------------------------------------------------------------
// opcode_sequencer
//
// Instruction-pointer half of the Opcode / OpcodeReady / OpcodeAck handshake
// of a Brainfuck core. It fetches 4-bit symbols from a program ROM that has a
// registered read, and hands one-hot opcodes to the core controller. Bracket
// symbols never reach the consumer. They are resolved here by testing
// DataZero and, when the loop must be skipped or repeated, by scanning the
// ROM for the matching bracket with a depth counter.
//
// Ports
//   Clk          system clock; all state changes on the rising edge
//   Rst          synchronous, active-high reset (highest priority)
//   IpAddr       ROM address / instruction pointer
//   RomData      ROM symbol; reflects IpAddr of the previous cycle
//   DataZero     current data cell is zero (sampled in DECODE only)
//   Opcode       one-hot opcode; stable while OpcodeReady is high
//   OpcodeReady  Opcode valid
//   OpcodeAck    consumer accepts Opcode (transfer when Ready & Ack)
//   Halted       HALT symbol reached (sticky until Rst)
//   Error        unmatched bracket or depth overflow (sticky until Rst)
// -----------------------------------------------------------------------------
module opcode_sequencer #(
    parameter int ADDR_WIDTH  = 12,
    parameter int DEPTH_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    output logic [ADDR_WIDTH-1:0] IpAddr,
    input  logic [3:0]            RomData,
    input  logic                  DataZero,
    output logic [15:0]           Opcode,
    output logic                  OpcodeReady,
    input  logic                  OpcodeAck,
    output logic                  Halted,
    output logic                  Error
);

    localparam logic [3:0] SYM_OPEN  = 4'd5;
    localparam logic [3:0] SYM_CLOSE = 4'd6;
    localparam logic [3:0] SYM_HALT  = 4'd15;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_READY,
        S_SRCH_ADDR,
        S_SRCH_DATA,
        S_HALT,
        S_ERROR
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ip;
    logic [15:0]             r_opcode;
    logic                    r_ready;
    logic                    r_halted;
    logic                    r_error;
    logic [DEPTH_WIDTH-1:0]  r_depth;
    logic                    r_dir_back;   // 1: scanning toward address 0

    logic                    w_sym_exec;
    logic [15:0]             w_onehot;
    logic                    w_ip_max;
    logic                    w_ip_zero;
    logic                    w_depth_max;
    logic                    w_deeper;
    logic                    w_shallower;
    logic                    w_scan_edge;

    // Symbols that the consumer executes. Their opcode bit equals the symbol
    // value, so the one-hot opcode is a plain shift.
    assign w_sym_exec  = (RomData == 4'd1) || (RomData == 4'd2) ||
                         (RomData == 4'd3) || (RomData == 4'd4) ||
                         (RomData == 4'd7) || (RomData == 4'd8);
    assign w_onehot    = 16'd1 << RomData;

    assign w_ip_max    = (r_ip == {ADDR_WIDTH{1'b1}});
    assign w_ip_zero   = (r_ip == {ADDR_WIDTH{1'b0}});
    assign w_depth_max = (r_depth == {DEPTH_WIDTH{1'b1}});

    // During a scan, the bracket that opens a nested level depends on the
    // direction: '[' going forward, ']' going backward.
    assign w_deeper    = r_dir_back ? (RomData == SYM_CLOSE) : (RomData == SYM_OPEN);
    assign w_shallower = r_dir_back ? (RomData == SYM_OPEN)  : (RomData == SYM_CLOSE);
    // The last address a scan may visit before running off the ROM.
    assign w_scan_edge = r_dir_back ? w_ip_zero : w_ip_max;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= S_FETCH;
            r_ip       <= '0;
            r_opcode   <= '0;
            r_ready    <= 1'b0;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_depth    <= '0;
            r_dir_back <= 1'b0;
        end else begin
            case (r_state)
                // IpAddr is stable for one cycle so that the ROM read lands.
                S_FETCH: begin
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    if (RomData == SYM_OPEN) begin
                        if (!DataZero) begin
                            r_ip    <= r_ip + ADDR_WIDTH'(1);
                            r_state <= S_FETCH;
                        end else if (w_ip_max) begin
                            // Nothing left to scan: the '[' cannot be matched.
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_depth    <= DEPTH_WIDTH'(1);
                            r_dir_back <= 1'b0;
                            r_ip       <= r_ip + ADDR_WIDTH'(1);
                            r_state    <= S_SRCH_ADDR;
                        end
                    end else if (RomData == SYM_CLOSE) begin
                        if (DataZero) begin
                            r_ip    <= r_ip + ADDR_WIDTH'(1);
                            r_state <= S_FETCH;
                        end else if (w_ip_zero) begin
                            // Nothing left to scan: the ']' cannot be matched.
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_depth    <= DEPTH_WIDTH'(1);
                            r_dir_back <= 1'b1;
                            r_ip       <= r_ip - ADDR_WIDTH'(1);
                            r_state    <= S_SRCH_ADDR;
                        end
                    end else if (RomData == SYM_HALT) begin
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else if (w_sym_exec) begin
                        r_opcode <= w_onehot;
                        r_ready  <= 1'b1;
                        r_state  <= S_READY;
                    end else begin
                        // NOP and reserved symbols; the increment wraps.
                        r_ip    <= r_ip + ADDR_WIDTH'(1);
                        r_state <= S_FETCH;
                    end
                end

                // Single outstanding opcode: nothing advances until accepted.
                S_READY: begin
                    if (OpcodeAck) begin
                        r_ready  <= 1'b0;
                        r_opcode <= '0;
                        r_ip     <= r_ip + ADDR_WIDTH'(1);
                        r_state  <= S_FETCH;
                    end
                end

                S_SRCH_ADDR: begin
                    r_state <= S_SRCH_DATA;
                end

                S_SRCH_DATA: begin
                    if (w_deeper && w_depth_max) begin
                        r_error <= 1'b1;
                        r_state <= S_ERROR;
                    end else if (w_shallower && (r_depth == DEPTH_WIDTH'(1))) begin
                        // Match found. Resume just past it in both directions:
                        // forward skips the loop, backward re-enters the body.
                        r_depth <= '0;
                        r_ip    <= r_ip + ADDR_WIDTH'(1);
                        r_state <= S_FETCH;
                    end else begin
                        if (w_deeper) begin
                            r_depth <= r_depth + DEPTH_WIDTH'(1);
                        end else if (w_shallower) begin
                            r_depth <= r_depth - DEPTH_WIDTH'(1);
                        end
                        if (w_scan_edge) begin
                            r_error <= 1'b1;
                            r_state <= S_ERROR;
                        end else begin
                            r_ip    <= r_dir_back ? (r_ip - ADDR_WIDTH'(1))
                                                  : (r_ip + ADDR_WIDTH'(1));
                            r_state <= S_SRCH_ADDR;
                        end
                    end
                end

                // Sticky terminal states; IpAddr frozen, nothing offered.
                S_HALT:  r_state <= S_HALT;
                S_ERROR: r_state <= S_ERROR;

                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign IpAddr      = r_ip;
    assign Opcode      = r_opcode;
    assign OpcodeReady = r_ready;
    assign Halted      = r_halted;
    assign Error       = r_error;

endmodule

// File: tb/tb_opcode_sequencer.sv
// -----------------------------------------------------------------------------
// tb_opcode_sequencer
//
// Directed bench for opcode_sequencer with a 16-word program ROM
// (ADDR_WIDTH=4) and a 2-bit depth counter, so that depth overflow can be
// reached. Each test pushes its expected {opcode, address} transfers into a
// queue. An independent monitor pops the queue on every accepted transfer and
// compares. Timing, boundary and terminal-state checks are made inline.
// -----------------------------------------------------------------------------
module tb_opcode_sequencer;

    localparam int AW = 4;
    localparam int DW = 2;

    logic          Clk;
    logic          Rst;
    logic [AW-1:0] IpAddr;
    logic [3:0]    RomData;
    logic          DataZero;
    logic [15:0]   Opcode;
    logic          OpcodeReady;
    logic          OpcodeAck;
    logic          Halted;
    logic          Error;

    opcode_sequencer #(.ADDR_WIDTH(AW), .DEPTH_WIDTH(DW)) dut (
        .Clk         (Clk),
        .Rst         (Rst),
        .IpAddr      (IpAddr),
        .RomData     (RomData),
        .DataZero    (DataZero),
        .Opcode      (Opcode),
        .OpcodeReady (OpcodeReady),
        .OpcodeAck   (OpcodeAck),
        .Halted      (Halted),
        .Error       (Error)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Program ROM with a registered read.
    logic [3:0] rom [16];
    always @(posedge Clk) RomData <= rom[IpAddr];

    typedef struct {
        logic [15:0]   op;
        logic [AW-1:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void push(input logic [15:0] op, input logic [AW-1:0] addr);
        exp_t e;
        e.op   = op;
        e.addr = addr;
        exp_q.push_back(e);
    endfunction

    // Monitor: every handshake transfer consumes one expected entry.
    always @(negedge Clk) begin
        if (!Rst && OpcodeReady && OpcodeAck) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_opcode: got 0x%0h at 0x%0h, expected none",
                         Opcode, IpAddr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("opcode", int'(Opcode), int'(e.op));
                chk("opcode_addr", int'(IpAddr), int'(e.addr));
                $display("transfer opcode=0x%04h addr=%0d", Opcode, IpAddr);
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Reset is asserted while the ROM is reloaded so the DUT cannot run stale code.
    task automatic start_reset();
        Rst = 1'b1;
        tick();
        exp_q.delete();
        for (int i = 0; i < 16; i++) rom[i] = 4'd0;
    endtask

    task automatic end_reset(input string name);
        tick();
        chk({name, "_rst_ip"},    int'(IpAddr), 0);
        chk({name, "_rst_op"},    int'(Opcode), 0);
        chk({name, "_rst_rdy"},   int'(OpcodeReady), 0);
        chk({name, "_rst_halt"},  int'(Halted), 0);
        chk({name, "_rst_err"},   int'(Error), 0);
        Rst = 1'b0;
    endtask

    task automatic wait_for(input int max, input bit want_err, input string name);
        int n;
        n = 0;
        while (!(want_err ? Error : Halted) && n < max) begin
            tick();
            n++;
        end
        chk(name, int'(want_err ? Error : Halted), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        Rst       = 1'b1;
        DataZero  = 1'b0;
        OpcodeAck = 1'b0;

        // T1: "+>." HALT with ack held high; latency and spacing.
        start_reset();
        rom[0] = 4'd1; rom[1] = 4'd3; rom[2] = 4'd7; rom[3] = 4'd15;
        OpcodeAck = 1'b1;
        DataZero  = 1'b0;
        push(16'h0002, 0); push(16'h0008, 1); push(16'h0080, 2);
        end_reset("t1");
        tick(); chk("t1_lat_c1", int'(OpcodeReady), 0);
        tick(); chk("t1_lat_c2", int'(OpcodeReady), 1);
        tick(); chk("t1_gap_fetch", int'(OpcodeReady), 0);
        tick(); chk("t1_gap_decode", int'(OpcodeReady), 0);
        tick(); chk("t1_second_rdy", int'(OpcodeReady), 1);
        wait_for(40, 1'b0, "t1_halted");
        chk("t1_halt_ip", int'(IpAddr), 3);
        chk("t1_halt_rdy", int'(OpcodeReady), 0);
        chk("t1_queue", exp_q.size(), 0);

        // T2: "," held without ack for 6 cycles.
        start_reset();
        rom[0] = 4'd8; rom[1] = 4'd15;
        OpcodeAck = 1'b0;
        end_reset("t2");
        tick(); tick();
        for (int i = 0; i < 6; i++) begin
            chk("t2_hold_rdy", int'(OpcodeReady), 1);
            chk("t2_hold_op", int'(Opcode), 16'h0100);
            chk("t2_hold_ip", int'(IpAddr), 0);
            tick();
        end
        push(16'h0100, 0);
        OpcodeAck = 1'b1;
        tick();
        chk("t2_ack_rdy", int'(OpcodeReady), 0);
        chk("t2_ack_op", int'(Opcode), 0);
        OpcodeAck = 1'b0;
        wait_for(20, 1'b0, "t2_halted");
        chk("t2_halt_ip", int'(IpAddr), 1);
        chk("t2_queue", exp_q.size(), 0);

        // T3: "[+[-]]." with DataZero=1 skips the nested loop.
        start_reset();
        rom[0] = 4'd5; rom[1] = 4'd1; rom[2] = 4'd5; rom[3] = 4'd2;
        rom[4] = 4'd6; rom[5] = 4'd6; rom[6] = 4'd7; rom[7] = 4'd15;
        OpcodeAck = 1'b1;
        DataZero  = 1'b1;
        push(16'h0080, 6);
        end_reset("t3");
        wait_for(80, 1'b0, "t3_halted");
        chk("t3_halt_ip", int'(IpAddr), 7);
        chk("t3_queue", exp_q.size(), 0);

        // T4: "+[-]" HALT; the loop body runs twice via a backward scan.
        start_reset();
        rom[0] = 4'd1; rom[1] = 4'd5; rom[2] = 4'd2; rom[3] = 4'd6; rom[4] = 4'd15;
        OpcodeAck = 1'b1;
        DataZero  = 1'b0;
        push(16'h0002, 0); push(16'h0004, 2); push(16'h0004, 2);
        end_reset("t4");
        cnt = 0;
        for (int i = 0; i < 80 && cnt < 2; i++) begin
            tick();
            if (OpcodeReady && Opcode == 16'h0004) cnt++;
        end
        chk("t4_minus_seen", cnt, 2);
        DataZero = 1'b1;
        wait_for(40, 1'b0, "t4_halted");
        chk("t4_halt_ip", int'(IpAddr), 4);
        chk("t4_queue", exp_q.size(), 0);

        // T5: "[+" with DataZero=1 runs off the end of the ROM.
        start_reset();
        rom[0] = 4'd5; rom[1] = 4'd1;
        OpcodeAck = 1'b0;
        DataZero  = 1'b1;
        end_reset("t5");
        wait_for(80, 1'b1, "t5_error");
        chk("t5_err_ip", int'(IpAddr), 15);
        chk("t5_err_rdy", int'(OpcodeReady), 0);
        chk("t5_err_halt", int'(Halted), 0);
        tick(); tick(); tick();
        chk("t5_sticky_err", int'(Error), 1);
        chk("t5_sticky_ip", int'(IpAddr), 15);

        // T6: same program, reset mid-scan, then a clean refetch of address 0.
        start_reset();
        rom[0] = 4'd5; rom[1] = 4'd1;
        DataZero = 1'b1;
        end_reset("t6");
        repeat (10) tick();
        Rst = 1'b1;
        tick();
        chk("t6_midrst_ip", int'(IpAddr), 0);
        chk("t6_midrst_err", int'(Error), 0);
        chk("t6_midrst_rdy", int'(OpcodeReady), 0);
        DataZero  = 1'b0;
        OpcodeAck = 1'b1;
        push(16'h0002, 1);
        Rst = 1'b0;
        tick(); chk("t6_decode_ip", int'(IpAddr), 0);
        tick(); chk("t6_refetch_ip", int'(IpAddr), 1);
        tick(); tick();
        chk("t6_plus_rdy", int'(OpcodeReady), 1);

        // T7: "[[[[" with DataZero=1 overflows the 2-bit depth counter.
        start_reset();
        rom[0] = 4'd5; rom[1] = 4'd5; rom[2] = 4'd5; rom[3] = 4'd5;
        OpcodeAck = 1'b0;
        DataZero  = 1'b1;
        end_reset("t7");
        wait_for(40, 1'b1, "t7_depth_error");
        chk("t7_err_ip", int'(IpAddr), 3);

        // T8: "-]" with DataZero=0 scans backward past address 0.
        start_reset();
        rom[0] = 4'd2; rom[1] = 4'd6;
        OpcodeAck = 1'b1;
        DataZero  = 1'b0;
        push(16'h0004, 0);
        end_reset("t8");
        wait_for(40, 1'b1, "t8_back_error");
        chk("t8_err_ip", int'(IpAddr), 0);
        chk("t8_queue", exp_q.size(), 0);

        // T9: "+" followed by NOPs; IpAddr wraps from 15 to 0 and refetches '+'.
        start_reset();
        rom[0] = 4'd1;
        OpcodeAck = 1'b1;
        DataZero  = 1'b0;
        push(16'h0002, 0); push(16'h0002, 0);
        end_reset("t9");
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        chk("t9_wrap_queue", exp_q.size(), 0);
        Rst = 1'b1;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/opcode_sequencer.md
Name: opcode_sequencer

Overview:
- Instruction-pointer side of the Opcode / OpcodeReady / OpcodeAck handshake.
- Fetches 4-bit Brainfuck symbols from program ROM and presents one-hot 16-bit opcodes to the core controller.
- Resolves '[' and ']' internally: tests DataZero and scans for the matching bracket with a depth counter.
- Signals halt and program-structure errors.

Parameters:
- ADDR_WIDTH, 12, program ROM address width.
- DEPTH_WIDTH, 8, bracket-depth counter width.

Ports:
- Clk  in  1  system clock, all state changes on rising edge.
- Rst  in  1  synchronous active-high reset.
- IpAddr  out  ADDR_WIDTH  ROM address (instruction pointer).
- RomData  in  4  ROM symbol; RomData at cycle t reflects IpAddr at cycle t-1.
- DataZero  in  1  current data cell is zero; valid whenever OpcodeReady=0.
- Opcode  out  16  one-hot opcode; stable while OpcodeReady=1.
- OpcodeReady  out  1  Opcode valid.
- OpcodeAck  in  1  consumer accepts Opcode; transfer when OpcodeReady & OpcodeAck.
- Halted  out  1  HALT symbol reached.
- Error  out  1  unmatched bracket or depth overflow.

Behaviour:
- Reset (Rst sampled high): synchronous, highest priority, also mid-search.
  - IpAddr=0, Opcode=0, OpcodeReady=0, Halted=0, Error=0, depth=0, state=FETCH.
- Symbol map:
  - 0 NOP, 1 '+', 2 '-', 3 '>', 4 '<', 5 '[', 6 ']', 7 '.', 8 ',', 15 HALT.
  - 9-14 are reserved and treated as NOP.
- Opcode bits:
  - '+' bit1, '-' bit2, '>' bit3, '<' bit4, '.' bit7, ',' bit8.
  - All other bits are always 0.
- States: FETCH, DECODE, READY, SRCH_ADDR, SRCH_DATA, HALT, ERROR.
- FETCH: IpAddr holds the target address; next cycle goes to DECODE.
- DECODE (RomData valid):
  - NOP/reserved: IpAddr+1, then FETCH.
  - Executable symbol: load Opcode, OpcodeReady=1, then READY. Opcode is presented 2 cycles after entering FETCH.
  - '[' with DataZero=1: depth=1, IpAddr+1, then SRCH_ADDR (forward). With DataZero=0: IpAddr+1, then FETCH.
  - ']' with DataZero=0: depth=1, IpAddr-1, then SRCH_ADDR (backward). With DataZero=1: IpAddr+1, then FETCH.
  - HALT: Halted=1, then HALT.
- READY: hold Opcode and IpAddr unchanged until OpcodeAck=1. On that edge: OpcodeReady=0, Opcode=0, IpAddr+1, then FETCH. No pipelining: at most one opcode outstanding.
- Search: two cycles per scanned symbol (SRCH_ADDR, then SRCH_DATA evaluates RomData). Direction is latched on entry.
  - Forward: '[' depth+1, ']' depth-1. When depth reaches 0: IpAddr = match+1, then FETCH. Otherwise IpAddr+1, then SRCH_ADDR.
  - Backward: ']' depth+1, '[' depth-1. When depth reaches 0: IpAddr = match+1 (loop body re-entered), then FETCH. Otherwise IpAddr-1.
  - Non-bracket symbols are ignored, including HALT.
- Boundaries:
  - Forward scan at IpAddr = all-ones without a match: Error=1, then ERROR. No wrap.
  - Backward scan at IpAddr = 0 without a match: Error=1, then ERROR.
  - depth increment from all-ones: Error=1, then ERROR. No wrap.
  - Non-search increment of IpAddr from all-ones wraps to 0.
- HALT and ERROR are sticky until Rst. In both: OpcodeReady=0 and IpAddr frozen.
- OpcodeAck is ignored outside READY. DataZero is sampled only in DECODE.

Test Plan:
- ROM "+>.", 15; hold OpcodeAck=1 → Opcode 0x0002 @IpAddr0, 0x0008 @1, 0x0080 @2; each OpcodeReady rises 2 cycles after FETCH; then Halted=1 with IpAddr=3.
- ROM "," with OpcodeAck held 0 for 6 cycles → OpcodeReady=1, Opcode=0x0100 and IpAddr=0 stable all 6 cycles; ack pulse → OpcodeReady=0 next cycle.
- ROM "[+[-]]." with DataZero=1 → first opcode is 0x0080 at IpAddr=6; no '+'/'-' opcodes emitted; maximum depth reached is 2.
- ROM "+[-]", 15; DataZero=0 through the first ']' and 1 thereafter → opcodes 0x0002, 0x0004, 0x0004, then Halted with IpAddr=4; IpAddr returns to 2 after the backward scan.
- ROM "[+" with DataZero=1, ADDR_WIDTH=4 → Error=1 after the scan reaches address 15; OpcodeReady stays 0.
- Same as previous scenario, Rst pulsed mid-scan → next cycle IpAddr=0, Error=0, state FETCH; clean refetch of address 0.
